// File: rtl/store_unit.sv
// store_unit: aligns SB/SH/SW data onto a 32-bit bus and runs req/gnt/rvalid.
// Optional bus timeout is compiled in when STORE_UNIT_TIMEOUT_EN is defined.
module store_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            st_valid_i,
    output logic            st_ready_o,
    input  logic [2:0]      st_funct3_i,
    input  logic [XLEN-1:0] st_addr_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic            st_done_o,
    output logic            st_misaligned_o,
    output logic            st_err_o,
    output logic            data_req_o,
    output logic            data_we_o,
    output logic [XLEN-1:0] data_addr_o,
    output logic [3:0]      data_be_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic            data_gnt_i,
    input  logic            data_rvalid_i,
    input  logic            data_err_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            mis_q, mis_d;
    logic            err_q, err_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;

    logic            timeout;
    logic            legal;
    logic            misaligned;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] lane_wdata;

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        lane_be    = 4'b0000;
        lane_wdata = '0;
        unique case (1'b1)
            st_funct3_i == 3'b000: begin
                legal      = 1'b1;
                lane_be    = 4'b0001 << st_addr_i[1:0];
                lane_wdata = {4{st_data_i[7:0]}};
            end
            st_funct3_i == 3'b001: begin
                legal      = 1'b1;
                misaligned = st_addr_i[0];
                lane_be    = 4'b0011 << st_addr_i[1:0];
                lane_wdata = {2{st_data_i[15:0]}};
            end
            st_funct3_i == 3'b010: begin
                legal      = 1'b1;
                misaligned = |st_addr_i[1:0];
                lane_be    = 4'b1111;
                lane_wdata = st_data_i;
            end
            default: ;
        endcase
    end

`ifdef STORE_UNIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Held at zero in IDLE so it starts from zero on every entry to REQ.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        req_d   = req_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                req_d   = 1'b0;
                if (st_valid_i && ready_q) begin
                    if (!legal) begin
                        err_d = 1'b1;
                    end else if (misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        ready_d = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = {st_addr_i[XLEN-1:2], 2'b00};
                        be_d    = lane_be;
                        wdata_d = lane_wdata;
                    end
                end
            end
            REQ: begin
                if (timeout) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (data_gnt_i) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                end
            end
            WAIT: begin
                if (data_rvalid_i) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    done_d  = !data_err_i;
                    err_d   = data_err_i;
                end else if (timeout) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    assign st_ready_o      = ready_q;
    assign st_done_o       = done_q;
    assign st_misaligned_o = mis_q;
    assign st_err_o        = err_q;
    assign data_req_o      = req_q;
    assign data_we_o       = req_q;
    assign data_addr_o     = addr_q;
    assign data_be_o       = be_q;
    assign data_wdata_o    = wdata_q;

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: randomized scoreboard bench for store_unit with a bus responder.
// Covers the timeout path when STORE_UNIT_TIMEOUT_EN is defined.
module tb_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [2:0]  st_funct3_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic        st_done_o;
    logic        st_misaligned_o;
    logic        st_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;

    store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk),
        .rstn_i(rstn_i),
        .st_valid_i(st_valid_i),
        .st_ready_o(st_ready_o),
        .st_funct3_i(st_funct3_i),
        .st_addr_i(st_addr_i),
        .st_data_i(st_data_i),
        .st_done_o(st_done_o),
        .st_misaligned_o(st_misaligned_o),
        .st_err_o(st_err_o),
        .data_req_o(data_req_o),
        .data_we_o(data_we_o),
        .data_addr_o(data_addr_o),
        .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i),
        .data_err_i(data_err_i)
    );

    always #5 clk = ~clk;

    // kind: 0 = done, 1 = misaligned, 2 = error
    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    // gd < 0 means the bus never grants
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gd;
        int          rd;
        bit          err;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, st_ready_o, 0);
        check({tag, "_done"}, st_done_o, 0);
        check({tag, "_mis"}, st_misaligned_o, 0);
        check({tag, "_err"}, st_err_o, 0);
        check({tag, "_req"}, data_req_o, 0);
        check({tag, "_we"}, data_we_o, 0);
        check({tag, "_addr"}, data_addr_o, 0);
        check({tag, "_be"}, data_be_o, 0);
        check({tag, "_wdata"}, data_wdata_o, 0);
    endtask

    // Reference: access size in bytes, byte lane = offset, data byte repeats per size.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] d, output int kind,
                                  output logic [3:0] be, output logic [31:0] wd);
        int size;
        int off;
        kind = 0;
        be   = 4'b0000;
        wd   = '0;
        if (f3 > 3'd2) begin
            kind = 2;
            return;
        end
        size = 1 << f3;
        off  = int'(a % 4);
        if (a % size != 0) begin
            kind = 1;
            return;
        end
        be = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % size) +: 8];
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input int gd, input int rd, input bit e, input bit expect_it);
        int          kind;
        logic [3:0]  be;
        logic [31:0] wd;
        int          w;
        exp_t        x;
        plan_t       p;
        w = 0;
        while (!st_ready_o && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", st_ready_o, 1);
        model(f3, a, d, kind, be, wd);
        st_valid_i  = 1'b1;
        st_funct3_i = f3;
        st_addr_i   = a;
        st_data_i   = d;
        if (kind == 0) begin
            p.addr  = a - (a % 4);
            p.be    = be;
            p.wdata = wd;
            p.gd    = gd;
            p.rd    = rd;
            p.err   = e;
            plan_q.push_back(p);
            if (gd < 0) begin
                kind  = 2;
                x.cyc = cyc + 1 + TO;
            end else begin
                if (e) kind = 2;
                x.cyc = cyc + 3 + gd + rd;
            end
        end else begin
            x.cyc = cyc + 1;
        end
        x.kind = kind;
        if (expect_it) exp_q.push_back(x);
        @(negedge clk);
        st_valid_i = 1'b0;
    endtask

    // Completion monitor
    initial begin
        int   n;
        int   k;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn_i === 1'b1) begin
                n = int'(st_done_o) + int'(st_misaligned_o) + int'(st_err_o);
                if (n != 0) begin
                    check("pulse_onehot", n, 1);
                    check("ready_with_pulse", st_ready_o, 1);
                    k = st_done_o ? 0 : (st_misaligned_o ? 1 : 2);
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", k, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind", k, e.kind);
                        check("pulse_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    // Bus responder
    initial begin
        plan_t p;
        int    held;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn_i === 1'b1 && data_req_o) begin
                if (plan_q.size() == 0) begin
                    check("unexpected_req", data_req_o, 0);
                    held = 0;
                    while (data_req_o && held < 40) begin
                        @(negedge clk);
                        held++;
                    end
                end else begin
                    p = plan_q.pop_front();
                    check("bus_addr", data_addr_o, p.addr);
                    check("bus_be", data_be_o, p.be);
                    check("bus_wdata", data_wdata_o, p.wdata);
                    check("bus_we", data_we_o, 1);
                    if (p.gd < 0) begin
                        held = 0;
                        while (data_req_o && held < 40) begin
                            held++;
                            @(negedge clk);
                        end
                        check("timeout_req_cycles", held, TO);
                    end else begin
                        for (int i = 0; i < p.gd; i++) begin
                            data_rvalid_i = 1'($urandom % 2);
                            data_err_i    = 1'($urandom % 2);
                            @(negedge clk);
                            check("hold_req", data_req_o, 1);
                            check("hold_addr", data_addr_o, p.addr);
                            check("hold_be", data_be_o, p.be);
                            check("hold_wdata", data_wdata_o, p.wdata);
                        end
                        data_rvalid_i = 1'b0;
                        data_err_i    = 1'b0;
                        data_gnt_i    = 1'b1;
                        @(negedge clk);
                        data_gnt_i = 1'b0;
                        check("req_drop", data_req_o, 0);
                        repeat (p.rd) @(negedge clk);
                        data_rvalid_i = 1'b1;
                        data_err_i    = p.err;
                        @(negedge clk);
                        data_rvalid_i = 1'b0;
                        data_err_i    = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0]  r_f3;
    logic [31:0] r_a;
    int          w;

    initial begin
        rstn_i      = 1'b1;
        st_valid_i  = 1'b0;
        st_funct3_i = 3'b000;
        st_addr_i   = '0;
        st_data_i   = '0;
        #2 rstn_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn_i = 1'b1;
        @(negedge clk);
        check("ready_after_reset", st_ready_o, 1);

        issue(3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 1'b0, 1'b1);
        issue(3'b001, 32'h0000_2002, 32'h1234_5678, 3, 0, 1'b0, 1'b1);
        issue(3'b010, 32'h0000_3001, 32'h0000_0000, 0, 0, 1'b0, 1'b1);
        issue(3'b011, 32'h0000_3000, 32'h0000_0005, 0, 0, 1'b0, 1'b1);
        issue(3'b010, 32'h0000_4000, 32'hCAFE_F00D, 0, 1, 1'b1, 1'b1);
`ifdef STORE_UNIT_TIMEOUT_EN
        issue(3'b010, 32'h0000_5000, 32'h0BAD_BEEF, -1, 0, 1'b0, 1'b1);
`else
        issue(3'b010, 32'h0000_5000, 32'h0BAD_BEEF, 25, 2, 1'b0, 1'b1);
`endif

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain_directed", exp_q.size(), 0);

        // Reset while waiting for the write response
        issue(3'b000, 32'h0000_6001, 32'h0000_0077, 0, 8, 1'b0, 1'b0);
        w = 0;
        while (data_req_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("reached_wait", data_req_o, 0);
        @(negedge clk);
        rstn_i = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rstn_i = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", st_ready_o, 1);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            if ($urandom % 5 == 0) r_f3 = 3'($urandom_range(3, 7));
            else r_f3 = 3'($urandom_range(0, 2));
            r_a = $urandom;
            if ($urandom % 3 != 0) r_a[0] = 1'b0;
            if ($urandom % 2 != 0) r_a[1] = 1'b0;
            repeat ($urandom % 3) @(negedge clk);
            issue(r_f3, r_a, $urandom, $urandom_range(0, 5), $urandom_range(0, 5),
                  1'($urandom % 4 == 0), 1'b1);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        check("drain_exp", exp_q.size(), 0);
        check("drain_plan", plan_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
